// File: rtl/gray_bin_pkg.sv
// Shared definitions for the Gray-code conversion blocks: default width and
// reference helpers usable by any block that needs Gray/binary arithmetic.
package gray_bin_pkg;

    localparam int GRAY_BIN_DEFAULT_WIDTH = 3;

    // Low w bits of g converted to binary; bits at and above w are zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] b;
        logic        acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

    // True when more than one bit of d is set (clearing the lowest set bit leaves a residue).
    function automatic logic multi_bit(input logic [31:0] d);
        return (d & (d - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/gray_bin_comb.sv
// Stateless reflected-Gray to binary conversion: each binary bit is the XOR of
// the Gray bits from the MSB down to its own position.
module gray_bin_comb
    import gray_bin_pkg::*;
#(
    parameter int WIDTH = GRAY_BIN_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_comb
);

    // A reduction per bit rather than a ripple through bin_comb keeps each bit
    // free of dependencies on its neighbours in the same vector.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin_comb[gi] = ^gray_in[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_bin.sv
// Registered Gray-to-binary converter, one cycle latency, one word per clock.
// Define GRAY_BIN_STEP_CHECK_EN to add the multi-bit step checker and step_err port.
module gray_bin
    import gray_bin_pkg::*;
#(
    parameter int WIDTH = GRAY_BIN_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out
`ifdef GRAY_BIN_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    logic [WIDTH-1:0] bin_comb;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;

    gray_bin_comb #(.WIDTH(WIDTH)) u_comb (
        .gray_in  (gray_in),
        .bin_comb (bin_comb)
    );

    always_comb begin
        valid_d = in_valid;
        bin_d   = bin_q;
        if (in_valid) begin
            bin_d = bin_comb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign bin_out   = bin_q;

`ifdef GRAY_BIN_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic             step_err_q, step_err_d;

    // Only accepted words advance the history; idle cycles never flag.
    always_comb begin
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        step_err_d  = 1'b0;
        if (in_valid) begin
            prev_d      = gray_in;
            have_prev_d = 1'b1;
            step_err_d  = have_prev_q && multi_bit(32'(gray_in ^ prev_q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            step_err_q  <= step_err_d;
        end
    end

    assign step_err = step_err_q;
`endif

endmodule

// File: tb/tb_gray_bin.sv
// Directed bench for gray_bin at WIDTH=3 and WIDTH=8 with a queue scoreboard;
// step_err checks are active when GRAY_BIN_STEP_CHECK_EN is defined.
module tb_gray_bin;
    import gray_bin_pkg::*;

    typedef struct {
        logic [7:0] bin;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv3, ov3, iv8, ov8;
    logic [2:0] g3, bo3;
    logic [7:0] g8, bo8;
`ifdef GRAY_BIN_STEP_CHECK_EN
    logic       se3, se8;
`endif

    exp_t       q3[$];
    exp_t       q8[$];
    int         errors = 0;
    int         checks = 0;
    logic [2:0] m3_prev, hold3;
    logic [7:0] m8_prev, hold8;
    logic       m3_have, m8_have;

    always #5 clk = ~clk;

    gray_bin #(.WIDTH(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv3),
        .gray_in   (g3),
        .out_valid (ov3),
        .bin_out   (bo3)
`ifdef GRAY_BIN_STEP_CHECK_EN
        ,
        .step_err  (se3)
`endif
    );

    gray_bin #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .gray_in   (g8),
        .out_valid (ov8),
        .bin_out   (bo8)
`ifdef GRAY_BIN_STEP_CHECK_EN
        ,
        .step_err  (se8)
`endif
    );

    // Independent reference: b = g ^ g>>1 ^ g>>2 ^ ...
    function automatic logic [31:0] ref_g2b(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive3(input logic v, input logic [2:0] g, input string tag);
        exp_t e;
        @(negedge clk);
        iv3 = v;
        g3  = g;
        if (v) begin
            e.bin = 8'(ref_g2b(32'(g)));
            e.err = m3_have && ($countones(g ^ m3_prev) > 1);
            q3.push_back(e);
            m3_prev = g;
            m3_have = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(ov3), 32'(v));
        if (v) begin
            if (q3.size() == 0) begin
                chk({tag, ".queue"}, 32'(q3.size()), 32'd1);
            end else begin
                e = q3.pop_front();
                chk({tag, ".bin"}, 32'(bo3), 32'(e.bin[2:0]));
`ifdef GRAY_BIN_STEP_CHECK_EN
                chk({tag, ".step_err"}, 32'(se3), 32'(e.err));
`endif
                hold3 = e.bin[2:0];
            end
        end else begin
            chk({tag, ".hold"}, 32'(bo3), 32'(hold3));
`ifdef GRAY_BIN_STEP_CHECK_EN
            chk({tag, ".step_err_idle"}, 32'(se3), 32'd0);
`endif
        end
        $display("txn w3 %s valid=%0b gray=%b bin_out=%b", tag, v, g, bo3);
    endtask

    task automatic drive8(input logic v, input logic [7:0] g, input logic [7:0] expbin,
                          input string tag);
        exp_t e;
        @(negedge clk);
        iv8 = v;
        g8  = g;
        if (v) begin
            e.bin = expbin;
            e.err = m8_have && ($countones(g ^ m8_prev) > 1);
            q8.push_back(e);
            m8_prev = g;
            m8_have = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(ov8), 32'(v));
        if (v) begin
            if (q8.size() == 0) begin
                chk({tag, ".queue"}, 32'(q8.size()), 32'd1);
            end else begin
                e = q8.pop_front();
                chk({tag, ".bin"}, 32'(bo8), 32'(e.bin));
`ifdef GRAY_BIN_STEP_CHECK_EN
                chk({tag, ".step_err"}, 32'(se8), 32'(e.err));
`endif
                hold8 = e.bin;
            end
        end else begin
            chk({tag, ".hold"}, 32'(bo8), 32'(hold8));
`ifdef GRAY_BIN_STEP_CHECK_EN
            chk({tag, ".step_err_idle"}, 32'(se8), 32'd0);
`endif
        end
        $display("txn w8 %s valid=%0b gray=%h bin_out=%h", tag, v, g, bo8);
    endtask

    initial begin
        logic [7:0] gr, bn;
        logic [2:0] gseq[9];
        rst_n = 1'b0;
        iv3 = 1'b0; g3 = '0; iv8 = 1'b0; g8 = '0;
        m3_prev = '0; m3_have = 1'b0; hold3 = '0;
        m8_prev = '0; m8_have = 1'b0; hold8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ov3", 32'(ov3), 32'd0);
        chk("reset.bo3", 32'(bo3), 32'd0);
        chk("reset.ov8", 32'(ov8), 32'd0);
        chk("reset.bo8", 32'(bo8), 32'd0);
`ifdef GRAY_BIN_STEP_CHECK_EN
        chk("reset.se3", 32'(se3), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Gray count 0..7 then the wrap back to 000.
        gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        for (int i = 0; i < 9; i++) drive3(1'b1, gseq[i], $sformatf("count%0d", i));

        // Gaps: valid 1,0,1.
        drive3(1'b1, 3'b011, "gap_a");
        drive3(1'b0, 3'b101, "gap_idle");
        drive3(1'b1, 3'b110, "gap_b");
        drive3(1'b0, 3'b000, "gap_idle2");

        // Step checker patterns.
        drive3(1'b1, 3'b000, "step_base");
        drive3(1'b1, 3'b011, "step_jump");
        drive3(1'b1, 3'b011, "step_repeat");
        drive3(1'b1, 3'b010, "step_single");

        // Reset mid-stream with bin_out=101 showing.
        drive3(1'b1, 3'b111, "pre_reset");
        #2;
        rst_n = 1'b0;
        iv3   = 1'b0;
        #1;
        chk("async_rst.ov3", 32'(ov3), 32'd0);
        chk("async_rst.bo3", 32'(bo3), 32'd0);
`ifdef GRAY_BIN_STEP_CHECK_EN
        chk("async_rst.se3", 32'(se3), 32'd0);
`endif
        m3_prev = '0; m3_have = 1'b0; hold3 = '0;
        m8_prev = '0; m8_have = 1'b0; hold8 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive3(1'b1, 3'b111, "post_reset");
        drive3(1'b0, 3'b000, "post_idle");

        // WIDTH=8 full sweep in Gray order, checked against a plain counter.
        for (int i = 0; i < 256; i++) begin
            bn = 8'(i);
            gr = bn ^ (bn >> 1);
            drive8(1'b1, gr, bn, $sformatf("sweep%0d", i));
        end

        // Random codes with random gaps against the reference conversion.
        for (int i = 0; i < 40; i++) begin
            gr = 8'($urandom_range(0, 255));
            chk("pkg_gray2bin", gray2bin(32'(gr), 8), ref_g2b(32'(gr)));
            drive8(1'($urandom_range(0, 1)), gr, 8'(ref_g2b(32'(gr))), $sformatf("rand%0d", i));
        end
        drive8(1'b0, 8'h00, 8'h00, "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
